// File: rtl/opamp_meas_pkg.sv
// Shared types and helpers for the op-amp gain capture path: FSM states,
// default sample width and the accumulator width rule.
package opamp_meas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DATA_W_DEFAULT = 12;

  // Sum of 2^log2_n samples of data_w bits needs log2_n guard bits.
  function automatic int acc_width(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

endpackage

// File: rtl/opamp_minmax_track.sv
// Running min/max of a signed stream; upd_min/upd_max already include the
// sample presented with en, so a caller can register the final extremes.
module opamp_minmax_track #(
  parameter int W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] upd_min,
  output logic signed [W-1:0] upd_max
);

  logic                seen;
  logic signed [W-1:0] min_q;
  logic signed [W-1:0] max_q;

  // The first sample after clear seeds both extremes.
  always_comb begin
    upd_min = din;
    upd_max = din;
    if (seen) begin
      upd_min = (din < min_q) ? din : min_q;
      upd_max = (din > max_q) ? din : max_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen  <= 1'b0;
      min_q <= '0;
      max_q <= '0;
    end else if (clr) begin
      seen  <= 1'b0;
      min_q <= '0;
      max_q <= '0;
    end else if (en) begin
      seen  <= 1'b1;
      min_q <= upd_min;
      max_q <= upd_max;
    end
  end

endmodule

// File: rtl/opamp_gain_sampler.sv
// Settle-then-average capture of the op-amp output ADC stream.
// Optional min/max/peak-to-peak outputs with OPAMP_GAIN_SAMPLER_MINMAX_EN.
module opamp_gain_sampler
  import opamp_meas_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int LOG2_N   = 4,
  parameter int SETTLE_N = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [DATA_W-1:0] res_mean,
  output logic                     busy
`ifdef OPAMP_GAIN_SAMPLER_MINMAX_EN
  ,
  output logic signed [DATA_W-1:0] res_min,
  output logic signed [DATA_W-1:0] res_max,
  output logic        [DATA_W:0]   res_pp
`endif
);

  localparam int ACC_W = acc_width(DATA_W, LOG2_N);
  localparam int N     = 1 << LOG2_N;
  localparam logic [7:0]        SETTLE_LAST = 8'((SETTLE_N > 0) ? SETTLE_N - 1 : 0);
  localparam logic [LOG2_N-1:0] ACC_LAST    = LOG2_N'(N - 1);

  state_t state, state_next;

  logic [7:0]              settle_cnt;
  logic [LOG2_N-1:0]       acc_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_shift;
  logic                    xfer;
  logic                    settle_done;
  logic                    acc_done;
  logic                    final_xfer;
  logic                    launch;

  assign xfer        = in_valid && in_ready;
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign acc_done    = (acc_cnt == ACC_LAST);
  assign final_xfer  = !abort && (state == ACCUM) && xfer && acc_done;
  assign launch      = !abort && (state == IDLE) && start;

  assign in_ext    = {{LOG2_N{in_data[DATA_W-1]}}, in_data};
  assign acc_sum   = acc + in_ext;
  assign acc_shift = acc_sum >>> LOG2_N;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Abort overrides every other event, including the HOLD handshake.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = (SETTLE_N == 0) ? ACCUM : SETTLE;
        SETTLE:  if (xfer && settle_done) state_next = ACCUM;
        ACCUM:   if (xfer && acc_done) state_next = HOLD;
        HOLD:    if (res_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == SETTLE) || (state == ACCUM);
    res_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      acc_cnt    <= '0;
      acc        <= '0;
      res_mean   <= '0;
    end else if (abort || launch) begin
      settle_cnt <= '0;
      acc_cnt    <= '0;
      acc        <= '0;
    end else begin
      if (state == SETTLE && xfer) settle_cnt <= settle_cnt + 8'd1;
      if (state == ACCUM && xfer) begin
        acc     <= acc_sum;
        acc_cnt <= acc_cnt + 1'b1;
      end
      // Mean includes the final sample, so it is taken from the running sum.
      if (final_xfer) res_mean <= acc_shift[DATA_W-1:0];
    end
  end

`ifdef OPAMP_GAIN_SAMPLER_MINMAX_EN
  logic signed [DATA_W-1:0] upd_min;
  logic signed [DATA_W-1:0] upd_max;

  opamp_minmax_track #(.W(DATA_W)) u_minmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (abort || launch),
    .en      (!abort && (state == ACCUM) && xfer),
    .din     (in_data),
    .upd_min (upd_min),
    .upd_max (upd_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_min <= '0;
      res_max <= '0;
      res_pp  <= '0;
    end else if (final_xfer) begin
      res_min <= upd_min;
      res_max <= upd_max;
      res_pp  <= {upd_max[DATA_W-1], upd_max} - {upd_min[DATA_W-1], upd_min};
    end
  end
`endif

endmodule

// File: tb/tb_opamp_gain_sampler.sv
// Directed bench for opamp_gain_sampler; min/max checks run when
// OPAMP_GAIN_SAMPLER_MINMAX_EN is defined.
module tb_opamp_gain_sampler;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [11:0] in_data = '0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic signed [11:0] res_mean;
  logic               busy;
`ifdef OPAMP_GAIN_SAMPLER_MINMAX_EN
  logic signed [11:0] res_min;
  logic signed [11:0] res_max;
  logic        [12:0] res_pp;
`endif

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int n_results = 0;
  logic rv_prev = 1'b0;

  opamp_gain_sampler #(.DATA_W(12), .LOG2_N(4), .SETTLE_N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_mean  (res_mean),
    .busy      (busy)
`ifdef OPAMP_GAIN_SAMPLER_MINMAX_EN
    ,
    .res_min   (res_min),
    .res_max   (res_max),
    .res_pp    (res_pp)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rv_prev <= res_valid;
    if (res_valid && !rv_prev) n_results <= n_results + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // One clock; transfers are counted from the handshake seen before the edge.
  task automatic step();
    if (in_valid && in_ready) xfer_cnt++;
    @(posedge clk);
    #1;
  endtask

  // Sample value for the idx-th transfer of a run (first 8 are settle samples).
  function automatic int gen(input int pat, input int idx);
    case (pat)
      0:       return 100;
      1:       return (idx < 8) ? 2047 : (((idx - 8) % 2 == 0) ? 7 : -8);
      2:       return (idx < 8) ? 2047 : -2048;
      default: return (idx < 8) ? 1000 : idx - 8;
    endcase
  endfunction

  task automatic run(input int pat, input int rnd, input int hold_wait, input int poke,
                     output int cycles, output int mean);
    logic [11:0] held;
    int x0;
    int stable;
    xfer_cnt = 0;
    in_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    cycles = 1;
    while (!res_valid && cycles < 300) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = 12'(gen(pat, xfer_cnt));
      start    = (poke != 0) && (cycles == 4);
      step();
      cycles++;
      if (poke != 0 && cycles == 5) check("poke_settle_busy", int'(busy), 1);
    end
    start = 1'b0;
    check("res_valid_rise", int'(res_valid), 1);
    check("in_ready_hold", int'(in_ready), 0);
    check("xfers_total", xfer_cnt, 24);
    mean = int'(res_mean);
    held = res_mean;
    x0 = xfer_cnt;
    stable = 1;
    in_valid = 1'b1;
    for (int i = 0; i < hold_wait; i++) begin
      start = (poke != 0) && (i == 0);
      step();
      if (res_mean !== held || !res_valid || !busy) stable = 0;
    end
    res_ready = 1'b1;
    start = (poke != 0);
    step();
    res_ready = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    check("hold_stable", stable, 1);
    check("hold_no_xfer", xfer_cnt, x0);
    check("post_hs_valid", int'(res_valid), 0);
    check("post_hs_busy", int'(busy), 0);
  endtask

  initial begin
    int cyc;
    int mean;
    int r0;
    int k;

    #12;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_mean", int'(res_mean), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Constant 100 with in_valid held high: latency and exact mean.
    run(0, 0, 0, 0, cyc, mean);
    check("const_latency", cyc, 25);
    check("const_mean", mean, 100);

    // +7/-8 alternation sums to -8; floor(-8/16) = -1.
    run(1, 0, 2, 0, cyc, mean);
    check("alt_mean", mean, -1);

    // Random valid gaps and a 10-cycle HOLD stall.
    run(1, 1, 10, 0, cyc, mean);
    check("rand_mean", mean, -1);

    // Abort on the 5th ACCUM sample.
    xfer_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 12'sd5;
    k = 0;
    while (xfer_cnt < 12 && k < 100) begin
      step();
      k++;
    end
    check("abort_reach_accum", xfer_cnt, 12);
    r0 = n_results;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(res_valid), 0);
    for (int i = 0; i < 30; i++) step();
    in_valid = 1'b0;
    check("abort_no_result", n_results, r0);
    check("abort_idle", int'(busy), 0);
    run(2, 0, 0, 0, cyc, mean);
    check("after_abort_mean", mean, -2048);

    // Starts during SETTLE, HOLD and the HOLD handshake are all ignored.
    r0 = n_results;
    run(0, 0, 3, 1, cyc, mean);
    for (int i = 0; i < 5; i++) step();
    check("poke_one_result", n_results, r0 + 1);
    check("poke_idle_busy", int'(busy), 0);
    check("poke_mean", mean, 100);

`ifdef OPAMP_GAIN_SAMPLER_MINMAX_EN
    run(3, 0, 0, 0, cyc, mean);
    check("ramp_mean", mean, 7);
    check("ramp_min", int'(res_min), 0);
    check("ramp_max", int'(res_max), 15);
    check("ramp_pp", int'(res_pp), 15);
`endif

    // Asynchronous reset in the middle of a run.
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("midrun_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", int'(busy), 0);
    check("midrun_rst_mean", int'(res_mean), 0);
    check("midrun_rst_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
